// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side front end for a synchronous FIFO with one-cycle
// registered read latency. Turns rd_en/rd_data/empty into a valid/ready
// stream through a 2-entry output buffer, sustaining one word per cycle
// under arbitrary backpressure.
// Optional: define FIFO_RD_STREAM_STATS_EN to enable the delivered-word
// counter on word_count; otherwise word_count is tied to zero.
module fifo_rd_stream #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [31:0]           word_count
);

   logic [1:0]            occ_q, occ_d;
   logic                  inflight_q;
   logic                  m_valid_q;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic                  pop;
   logic [1:0]            occ_after_pop;

   assign pop     = m_valid_q & m_ready;
   assign m_valid = m_valid_q;
   assign m_data  = buf0_q;

   // Strobe, capture steering and next occupancy. occ+inflight never exceeds
   // 2, and pop implies occ >= 1, so 2-bit arithmetic cannot wrap.
   always_comb begin
      occ_after_pop = occ_q - {1'b0, pop};
      occ_d         = occ_after_pop + {1'b0, inflight_q};
      // Only read if the word will still fit once it lands next cycle.
      fifo_rd_en    = !rst && enable && !fifo_empty && (occ_d <= 2'd1);
      buf0_d        = buf0_q;
      buf1_d        = buf1_q;
      if (pop) begin
         buf0_d = buf1_q;
      end
      if (inflight_q) begin
         // Arriving word becomes the head if nothing older remains.
         if (occ_after_pop == 2'd0) begin
            buf0_d = fifo_rd_data;
         end else begin
            buf1_d = fifo_rd_data;
         end
      end
   end

   // Buffer state and registered stream outputs; reset drops any in-flight word.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         m_valid_q  <= 1'b0;
         buf0_q     <= '0;
         buf1_q     <= '0;
      end else begin
         occ_q      <= occ_d;
         inflight_q <= fifo_rd_en;
         m_valid_q  <= (occ_d != 2'd0);
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
      end
   end

`ifdef FIFO_RD_STREAM_STATS_EN
   logic [31:0] word_count_q;

   // Count every delivered word; wraps naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_count_q <= 32'd0;
      end else if (pop) begin
         word_count_q <= word_count_q + 32'd1;
      end
   end

   assign word_count = word_count_q;
`else
   assign word_count = 32'd0;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: behavioural 8-deep FIFO, scoreboard monitor,
// per-cycle vector tables and directed multi-cycle sequences.
module tb_fifo_rd_stream;

   localparam int DW = 8;
`ifdef FIFO_RD_STREAM_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          enable = 1'b0;
   logic          m_ready = 1'b0;
   logic          fifo_rd_en, fifo_empty, m_valid;
   logic [DW-1:0] fifo_rd_data, m_data;
   logic [31:0]   word_count;

   always #5 clk = ~clk;

   fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .word_count(word_count)
   );

   // Behavioural FIFO, DEPTH=8, registered read data
   logic          wr_en = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic [DW-1:0] mem [8];
   logic [3:0]    cnt = 4'd0;
   logic [2:0]    wp = 3'd0, rp = 3'd0;
   logic          wr_ok, rd_ok;
   assign wr_ok      = wr_en && (cnt != 4'd8);
   assign rd_ok      = fifo_rd_en && (cnt != 4'd0);
   assign fifo_empty = (cnt == 4'd0);

   always @(posedge clk) begin
      if (rst) begin
         cnt <= 4'd0; wp <= 3'd0; rp <= 3'd0; fifo_rd_data <= '0;
      end else begin
         if (wr_ok) begin mem[wp] <= wr_data; wp <= wp + 3'd1; end
         if (rd_ok) begin fifo_rd_data <= mem[rp]; rp <= rp + 3'd1; end
         cnt <= cnt + 4'(wr_ok) - 4'(rd_ok);
      end
   end

   int passed = 0, total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Scoreboard monitor, samples 2 time units after the falling edge
   logic [DW-1:0] exp_q [$];
   int            pop_cnt = 0;
   int            outstanding = 0;
   bit            prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(negedge clk) begin
      #2;
      if (rst) begin
         outstanding = 0; prev_stall = 1'b0; pop_cnt = 0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 32'd1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
         end
         chk("occ_bound", 32'(outstanding <= 2), 32'd1);
         if (fifo_rd_en) chk("rd_while_empty", 32'(fifo_empty), 32'd0);
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL unexpected_word: got %0h expected none", m_data);
            end else begin
               chk("data_order", 32'(m_data), 32'(exp_q.pop_front()));
            end
            pop_cnt++;
         end
         outstanding += int'(fifo_rd_en && !fifo_empty) - int'(m_valid && m_ready);
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
      end
   end

   typedef struct {
      logic          en;
      logic          rdy;
      logic          rd_en;
      logic          vld;
      logic [DW-1:0] data;
   } vec_t;

   vec_t sw [4];
   vec_t el [11];

   function automatic logic [31:0] exp_wc();
      return STATS ? 32'(pop_cnt) : 32'd0;
   endfunction

   task automatic run_vec(input string tag, input vec_t v);
      @(negedge clk);
      enable = v.en; m_ready = v.rdy;
      #1;
      chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(v.rd_en));
      chk({tag, "_valid"}, 32'(m_valid), 32'(v.vld));
      if (v.vld) chk({tag, "_data"}, 32'(m_data), 32'(v.data));
      chk({tag, "_wc"}, word_count, exp_wc());
   endtask

   task automatic wr(input logic [DW-1:0] x);
      @(negedge clk);
      wr_en = 1'b1; wr_data = x; exp_q.push_back(x);
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk); n++;
      end
      #3;
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] rdbits, vbits;
      int strobes, base;
      int i;

      // single word: strobe, in flight, valid, gone
      sw[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      sw[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      sw[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hA5};
      sw[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      // enable dropped after the first strobe, then restored
      el[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      el[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      el[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h10};
      el[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      el[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      el[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      el[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
      el[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
      el[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h12};
      el[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h13};
      el[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

      // reset state
      enable = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_wc", word_count, 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      @(negedge clk);
      rst = 1'b0; enable = 1'b1; m_ready = 1'b1;

      // single word latency
      wr(8'hA5);
      foreach (sw[k]) run_vec("single", sw[k]);
      chk("single_wc_final", word_count, STATS ? 32'd1 : 32'd0);

      // streaming 8 words back to back
      enable = 1'b0;
      for (int k = 1; k <= 8; k++) wr(8'(k));
      rdbits = '0; vbits = '0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c == 0) enable = 1'b1;
         #1;
         rdbits[c] = fifo_rd_en;
         vbits[c]  = m_valid;
      end
      chk("stream_rd_pattern", 32'(rdbits), 32'h00FF);
      chk("stream_valid_pattern", 32'(vbits), 32'h03FC);
      wait_drain("stream", 20);

      // backpressure: 10 stalled cycles with 8 words queued
      enable = 1'b0; m_ready = 1'b0;
      for (int k = 1; k <= 8; k++) wr(8'(k));
      strobes = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (c == 0) enable = 1'b1;
         #1;
         strobes += int'(fifo_rd_en);
      end
      chk("bp_strobes", 32'(strobes), 32'd2);
      chk("bp_valid_held", 32'(m_valid), 32'd1);
      chk("bp_data_held", 32'(m_data), 32'h01);
      @(negedge clk);
      m_ready = 1'b1;
      wait_drain("bp", 30);

      // random stalls over 100 words with a concurrent writer
      base = pop_cnt;
      i = 0;
      while (i < 100) begin
         @(negedge clk);
         m_ready = 1'($urandom_range(0, 1));
         if (cnt < 4'd8) begin
            wr_en = 1'b1; wr_data = 8'(i); exp_q.push_back(8'(i)); i++;
         end else begin
            wr_en = 1'b0;
         end
      end
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(negedge clk);
      m_ready = 1'b1;
      wait_drain("rand", 60);
      chk("rand_count", 32'(pop_cnt - base), 32'd100);

      // enable low mid-stream
      enable = 1'b0; m_ready = 1'b1;
      for (int k = 0; k < 4; k++) wr(8'(8'h10 + k));
      foreach (el[k]) run_vec("enlow", el[k]);
      wait_drain("enlow", 10);

      // reset mid-transfer with one word held and one in flight
      enable = 1'b0; m_ready = 1'b0;
      for (int k = 1; k <= 4; k++) wr(8'(k));
      @(negedge clk); enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_ready = 1'b1; rst = 1'b1; exp_q.delete();
      #1;
      chk("mrst_rd_en_during", 32'(fifo_rd_en), 32'd0);
      @(negedge clk);
      rst = 1'b0; m_ready = 1'b0;
      #1;
      chk("mrst_valid", 32'(m_valid), 32'd0);
      chk("mrst_data", 32'(m_data), 32'd0);
      chk("mrst_wc", word_count, 32'd0);
      chk("mrst_rd_en", 32'(fifo_rd_en), 32'd0);
      m_ready = 1'b1;
      wr(8'h5A);
      wait_drain("post_rst", 10);
      chk("post_rst_wc", word_count, STATS ? 32'd1 : 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
